// File: rtl/stack_core.sv
// Stack-manipulation core: executes packed 7-bit opcodes against a private data stack,
// with overflow/underflow/illegal-opcode detection and a sticky first-fault report.
module stack_core #(
  parameter int          IDX   = -1,
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SLOTS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           push_value,
  input  logic                       push_en,
  input  logic [7*SLOTS-1:0]         instr,
  input  logic                       instr_en,
  input  logic                       pcp_step_en,
  input  logic                       clr_fault,
  output logic [27:0]                pcp,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       acore_idle,
  output logic                       fault,
  output logic [1:0]                 fault_code
);

  localparam int unsigned DW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned IW = 7 * SLOTS;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_DEPTH = 7'h01;
  localparam logic [6:0] OP_DUP   = 7'h02;
  localparam logic [6:0] OP_DROP  = 7'h03;
  localparam logic [6:0] OP_SWAP  = 7'h04;
  localparam logic [6:0] OP_OVER  = 7'h05;
  localparam logic [6:0] OP_EMPTY = 7'h06;
  localparam logic [6:0] OP_ROT   = 7'h07;

  localparam logic [1:0] FC_OVF = 2'b01;
  localparam logic [1:0] FC_UDF = 2'b10;
  localparam logic [1:0] FC_ILL = 2'b11;

  if (WIDTH < 8 || DEPTH < 2 || SLOTS < 1 || IDX < -1) begin : g_param_check
    $error("stack_core %0d: illegal parameterisation", IDX);
  end

  typedef enum logic [1:0] {IDLE, PUSH, EXEC, NEXT} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     icr;
  logic [SW-1:0]     slot;
  logic [WIDTH-1:0]  push_reg;
  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic [WIDTH-1:0]  stack_d [DEPTH];
  logic [DW-1:0]     depth_d;
  logic [WIDTH-1:0]  top_d;

  logic [6:0]        opcode;
  logic              legal, grows, full;
  logic [DW-1:0]     need;
  logic [DW-1:0]     t_idx, n_idx, r_idx, new_top_idx;
  logic [WIDTH-1:0]  t_val, n_val, r_val;

  logic              op_fault;
  logic [1:0]        op_code;
  logic              do_push, do_drop, do_zero;
  logic              set_t, set_n, set_r;
  logic [WIDTH-1:0]  push_data, new_t, new_n, new_r;

  assign opcode     = icr[6:0];
  assign full       = (depth == DW'(DEPTH));
  assign t_idx      = depth - DW'(1);
  assign n_idx      = depth - DW'(2);
  assign r_idx      = depth - DW'(3);
  assign acore_idle = (state_q == IDLE) && !push_en && !instr_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  // Next-state logic; push wins over execute when both are requested
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_en)       state_d = PUSH;
        else if (instr_en) state_d = EXEC;
      end
      PUSH: state_d = IDLE;
      EXEC: state_d = (slot < SW'(SLOTS - 1) && !op_fault) ? NEXT : IDLE;
      NEXT: state_d = EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Opcode decode: legality, minimum operand count, and whether it grows the stack
  always_comb begin
    legal = 1'b1;
    need  = '0;
    grows = 1'b0;
    case (opcode)
      OP_NOP, OP_EMPTY: ;
      OP_DEPTH: grows = 1'b1;
      OP_DUP:   begin need = DW'(1); grows = 1'b1; end
      OP_DROP:  need = DW'(1);
      OP_SWAP:  need = DW'(2);
      OP_OVER:  begin need = DW'(2); grows = 1'b1; end
      OP_ROT:   need = DW'(3);
      default:  legal = 1'b0;
    endcase
  end

  // Operand fetch for the top three items
  always_comb begin
    t_val = '0;
    n_val = '0;
    r_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DW'(i) == t_idx) t_val = stack_q[i];
      if (DW'(i) == n_idx) n_val = stack_q[i];
      if (DW'(i) == r_idx) r_val = stack_q[i];
    end
  end

  // Output/datapath logic: fault checks in priority order, then the stack edit
  always_comb begin
    op_fault  = 1'b0;
    op_code   = 2'b00;
    do_push   = 1'b0;
    do_drop   = 1'b0;
    do_zero   = 1'b0;
    set_t     = 1'b0;
    set_n     = 1'b0;
    set_r     = 1'b0;
    push_data = '0;
    new_t     = '0;
    new_n     = '0;
    new_r     = '0;
    if (state_q == PUSH) begin
      if (full) begin
        op_fault = 1'b1;
        op_code  = FC_OVF;
      end else begin
        do_push   = 1'b1;
        push_data = push_reg;
      end
    end else if (state_q == EXEC) begin
      if (!legal) begin
        op_fault = 1'b1;
        op_code  = FC_ILL;
      end else if (depth < need) begin
        op_fault = 1'b1;
        op_code  = FC_UDF;
      end else if (grows && full) begin
        op_fault = 1'b1;
        op_code  = FC_OVF;
      end else begin
        case (opcode)
          OP_DEPTH: begin do_push = 1'b1; push_data = WIDTH'(depth); end
          OP_DUP:   begin do_push = 1'b1; push_data = t_val; end
          OP_DROP:  do_drop = 1'b1;
          OP_SWAP:  begin set_t = 1'b1; new_t = n_val; set_n = 1'b1; new_n = t_val; end
          OP_OVER:  begin do_push = 1'b1; push_data = n_val; end
          OP_EMPTY: do_zero = 1'b1;
          OP_ROT: begin
            set_r = 1'b1; new_r = n_val;
            set_n = 1'b1; new_n = t_val;
            set_t = 1'b1; new_t = r_val;
          end
          default: ;
        endcase
      end
    end

    stack_d = stack_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_push && DW'(i) == depth) stack_d[i] = push_data;
      if (set_t && DW'(i) == t_idx)   stack_d[i] = new_t;
      if (set_n && DW'(i) == n_idx)   stack_d[i] = new_n;
      if (set_r && DW'(i) == r_idx)   stack_d[i] = new_r;
    end

    depth_d = depth;
    if (do_zero)      depth_d = '0;
    else if (do_push) depth_d = depth + DW'(1);
    else if (do_drop) depth_d = depth - DW'(1);

    new_top_idx = depth_d - DW'(1);
    top_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DW'(i) == new_top_idx) top_d = stack_d[i];
    end
  end

  // Stack, instruction register, pointer and fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q    <= '{default: '0};
      depth      <= '0;
      top        <= '0;
      pcp        <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      icr        <= '0;
      slot       <= '0;
      push_reg   <= '0;
    end else if (en) begin
      stack_q <= stack_d;
      depth   <= depth_d;
      top     <= top_d;
      if (pcp_step_en) pcp <= pcp + 28'd1;
      if (op_fault) begin
        fault <= 1'b1;
        if (!fault || clr_fault) fault_code <= op_code;
      end else if (clr_fault) begin
        fault      <= 1'b0;
        fault_code <= 2'b00;
      end
      if (state_q == IDLE) begin
        if (push_en) begin
          push_reg <= push_value;
        end else if (instr_en) begin
          icr  <= instr;
          slot <= '0;
        end
      end else if (state_q == NEXT) begin
        icr  <= icr >> 7;
        slot <= slot + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stack_core.sv
// Scoreboard bench for stack_core: a queue-based reference stack predicts depth/top/fault
// for every push, instruction word and fault clear.
module tb_stack_core;

  localparam int unsigned W = 56;
  localparam int unsigned D = 8;
  localparam int unsigned S = 2;

  logic           clk, rst_n, en;
  logic [W-1:0]   push_value;
  logic           push_en;
  logic [7*S-1:0] instr;
  logic           instr_en, pcp_step_en, clr_fault;
  logic [27:0]    pcp;
  logic [W-1:0]   top;
  logic [3:0]     depth;
  logic           acore_idle, fault;
  logic [1:0]     fault_code;

  stack_core #(.IDX(0), .WIDTH(W), .DEPTH(D), .SLOTS(S)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .push_value(push_value), .push_en(push_en),
    .instr(instr), .instr_en(instr_en), .pcp_step_en(pcp_step_en), .clr_fault(clr_fault),
    .pcp(pcp), .top(top), .depth(depth), .acore_idle(acore_idle), .fault(fault),
    .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   d;
    logic [W-1:0] t;
    logic         f;
    logic [1:0]   c;
  } snap_t;

  snap_t        exp_q[$];
  logic [W-1:0] mstk[$];
  logic         mf;
  logic [1:0]   mc;
  logic [27:0]  mpcp;
  int           vectors = 0;
  int           miscompares = 0;

  function automatic snap_t m_snap();
    snap_t s;
    s.d = 4'(mstk.size());
    s.t = (mstk.size() > 0) ? mstk[mstk.size()-1] : '0;
    s.f = mf;
    s.c = mc;
    return s;
  endfunction

  function automatic snap_t d_snap();
    snap_t s;
    s.d = depth;
    s.t = top;
    s.f = fault;
    s.c = fault_code;
    return s;
  endfunction

  function automatic void m_flag(input logic [1:0] code);
    if (!mf) mc = code;
    mf = 1'b1;
  endfunction

  function automatic bit m_op(input logic [6:0] op);
    int n;
    logic [W-1:0] tmp;
    n = mstk.size();
    case (op)
      7'h00: return 0;
      7'h01: begin if (n == D) begin m_flag(2'b01); return 1; end mstk.push_back(W'(n)); end
      7'h02: begin
        if (n < 1) begin m_flag(2'b10); return 1; end
        if (n == D) begin m_flag(2'b01); return 1; end
        mstk.push_back(mstk[n-1]);
      end
      7'h03: begin if (n < 1) begin m_flag(2'b10); return 1; end mstk.pop_back(); end
      7'h04: begin
        if (n < 2) begin m_flag(2'b10); return 1; end
        tmp = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = tmp;
      end
      7'h05: begin
        if (n < 2) begin m_flag(2'b10); return 1; end
        if (n == D) begin m_flag(2'b01); return 1; end
        mstk.push_back(mstk[n-2]);
      end
      7'h06: mstk.delete();
      7'h07: begin
        if (n < 3) begin m_flag(2'b10); return 1; end
        tmp = mstk[n-3]; mstk.delete(n-3); mstk.push_back(tmp);
      end
      default: begin m_flag(2'b11); return 1; end
    endcase
    return 0;
  endfunction

  function automatic void m_word(input logic [7*S-1:0] w);
    for (int s = 0; s < S; s++) begin
      if (m_op(w[7*s +: 7])) break;
    end
  endfunction

  task automatic wait_idle(input string tag, output int busy);
    busy = 0;
    while (!acore_idle && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    if (!acore_idle) begin
      vectors++;
      miscompares++;
      $display("FAIL %s idle-timeout: busy=%0d cycles, required idle within 50", tag, busy);
    end
  endtask

  task automatic drive_push(input logic [W-1:0] v, input string tag);
    snap_t e;
    @(negedge clk);
    push_value = v;
    push_en    = 1'b1;
    if (mstk.size() == D) m_flag(2'b01);
    else mstk.push_back(v);
    exp_q.push_back(m_snap());
    @(negedge clk);
    push_en = 1'b0;
    #1;
    vectors++;
    if (acore_idle !== 1'b0) begin
      miscompares++;
      $display("FAIL %s push-busy: acore_idle=%b, required 0", tag, acore_idle);
    end
    @(negedge clk);
    vectors++;
    if (acore_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL %s push-idle: acore_idle=%b, required 1", tag, acore_idle);
    end
    e = exp_q.pop_front();
    vectors++;
    if (d_snap() !== e) begin
      miscompares++;
      $display("FAIL %s push: got d=%0d t=%0h f=%0b c=%0b, required d=%0d t=%0h f=%0b c=%0b",
               tag, depth, top, fault, fault_code, e.d, e.t, e.f, e.c);
    end
  endtask

  task automatic drive_word(input logic [7*S-1:0] w, input int exp_busy, input string tag);
    snap_t e;
    int busy;
    @(negedge clk);
    instr    = w;
    instr_en = 1'b1;
    m_word(w);
    exp_q.push_back(m_snap());
    @(negedge clk);
    instr_en = 1'b0;
    #1;
    wait_idle(tag, busy);
    if (exp_busy > 0) begin
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy-cycles: got %0d, required %0d", tag, busy, exp_busy);
      end
    end
    e = exp_q.pop_front();
    vectors++;
    if (d_snap() !== e) begin
      miscompares++;
      $display("FAIL %s word: got d=%0d t=%0h f=%0b c=%0b, required d=%0d t=%0h f=%0b c=%0b",
               tag, depth, top, fault, fault_code, e.d, e.t, e.f, e.c);
    end
  endtask

  task automatic drive_clr(input string tag);
    snap_t e;
    @(negedge clk);
    clr_fault = 1'b1;
    mf = 1'b0;
    mc = 2'b00;
    exp_q.push_back(m_snap());
    @(negedge clk);
    clr_fault = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (d_snap() !== e) begin
      miscompares++;
      $display("FAIL %s clr: got d=%0d t=%0h f=%0b c=%0b, required d=%0d t=%0h f=%0b c=%0b",
               tag, depth, top, fault, fault_code, e.d, e.t, e.f, e.c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; push_value = '0; push_en = 1'b0; instr = '0;
    instr_en = 1'b0; pcp_step_en = 1'b0; clr_fault = 1'b0;
    #2 rst_n = 1'b0;
    mstk.delete(); mf = 1'b0; mc = 2'b00; mpcp = '0;
    #10;
    vectors++;
    if (d_snap() !== m_snap() || pcp !== 28'd0 || acore_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got d=%0d t=%0h f=%0b c=%0b pcp=%0h idle=%b, required all 0, idle 1",
               depth, top, fault, fault_code, pcp, acore_idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push();
    drive_push(W'(56'h11), "push11");
    drive_push(W'(56'h22), "push22");
    drive_push(W'(56'h33), "push33");
  endtask

  task automatic test_swap_dup();
    drive_word({7'h00, 7'h06}, 3, "empty");
    drive_push(W'(56'h11), "sd_push11");
    drive_push(W'(56'h22), "sd_push22");
    drive_word({7'h02, 7'h04}, 3, "swap_dup");
  endtask

  task automatic test_rot_over();
    drive_word({7'h06, 7'h00}, 3, "nop_empty");
    drive_push(W'(1), "ro_push1");
    drive_push(W'(2), "ro_push2");
    drive_push(W'(3), "ro_push3");
    drive_word({7'h05, 7'h07}, 3, "rot_over");
    drive_word({7'h00, 7'h01}, 3, "depth_op");
  endtask

  task automatic test_overflow();
    drive_push(W'(56'hAAAA_0000_0001), "fill6");
    drive_push(W'(56'hFFFF_FFFF_FFFF_FF), "fill7");
    drive_push(W'(56'h8000_0000_0000_00), "fill8");
    drive_word({7'h03, 7'h02}, 1, "dup_ovf");
    drive_word({7'h03, 7'h06}, 3, "empty_drop_udf");
    drive_clr("clr1");
    for (int i = 0; i < D; i++) drive_push(W'(100 + i), "fill_to_depth");
    drive_push(W'(56'hDEAD), "push_ovf");
    drive_clr("clr2");
  endtask

  task automatic test_illegal();
    drive_word({7'h00, 7'h7F}, 1, "illegal");
    drive_word({7'h03, 7'h02}, 1, "ovf_after_ill");
    drive_clr("clr3");
  endtask

  task automatic test_en_freeze();
    snap_t pre, e;
    int busy;
    drive_word({7'h00, 7'h06}, 3, "fz_empty");
    drive_push(W'(5), "fz_push5");
    drive_push(W'(6), "fz_push6");
    pre = m_snap();
    @(negedge clk);
    instr = {7'h02, 7'h04};
    instr_en = 1'b1;
    m_word(instr);
    exp_q.push_back(m_snap());
    @(negedge clk);
    instr_en = 1'b0;
    en = 1'b0;
    pcp_step_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (d_snap() !== pre || acore_idle !== 1'b0 || pcp !== mpcp) begin
        miscompares++;
        $display("FAIL freeze: got d=%0d t=%0h idle=%b pcp=%0h, required d=%0d t=%0h idle=0 pcp=%0h",
                 depth, top, acore_idle, pcp, pre.d, pre.t, mpcp);
      end
    end
    en = 1'b1;
    pcp_step_en = 1'b0;
    #1;
    wait_idle("freeze_resume", busy);
    e = exp_q.pop_front();
    vectors++;
    if (d_snap() !== e || pcp !== mpcp) begin
      miscompares++;
      $display("FAIL freeze_resume: got d=%0d t=%0h pcp=%0h, required d=%0d t=%0h pcp=%0h",
               depth, top, pcp, e.d, e.t, mpcp);
    end
  endtask

  task automatic test_pcp();
    @(negedge clk);
    pcp_step_en = 1'b1;
    repeat (5) @(negedge clk);
    pcp_step_en = 1'b0;
    mpcp = mpcp + 28'd5;
    vectors++;
    if (pcp !== mpcp) begin
      miscompares++;
      $display("FAIL pcp_step: got %0h, required %0h", pcp, mpcp);
    end
  endtask

  task automatic test_reset_midword();
    drive_push(W'(9), "rm_push");
    @(negedge clk);
    instr = {7'h02, 7'h02};
    instr_en = 1'b1;
    @(negedge clk);
    instr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    mstk.delete(); mf = 1'b0; mc = 2'b00; mpcp = '0;
    #1;
    vectors++;
    if (d_snap() !== m_snap() || pcp !== 28'd0 || acore_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midword: got d=%0d t=%0h pcp=%0h idle=%b, required 0/0/0/1",
               depth, top, pcp, acore_idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (d_snap() !== m_snap() || acore_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_resume: got d=%0d t=%0h idle=%b, required d=0 t=0 idle=1",
               depth, top, acore_idle);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      if (pick < 3) drive_push(W'({$urandom, $urandom}), "rnd_push");
      else if (pick == 9) drive_clr("rnd_clr");
      else drive_word({7'($urandom_range(0, 8)), 7'($urandom_range(0, 8))}, 0, "rnd_word");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push();
    test_swap_dup();
    test_rot_over();
    test_overflow();
    test_illegal();
    test_pcp();
    test_en_freeze();
    test_back_to_back();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
